param_fifo: RTL and testbench
=============================

# param_fifo

Parametrised synchronous FIFO, next generation of the team's 8-bit/16-entry fifo. It generalises data width and depth, provides true full (all DEPTH entries usable), and selects drop or overwrite-oldest at full. It adds a registered read port with valid strobe, programmable almost-full/almost-empty flags, and overflow/underflow event pulses. It sits between producer and consumer blocks in one clock domain.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- OVERWRITE, 0, full-write policy: 0 = drop incoming write, 1 = overwrite oldest entry
- AF_THRESH, DEPTH-2, almost_full asserted when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserted when count ≤ AE_THRESH (0..DEPTH-1)
- Local AW = $clog2(DEPTH); count width is AW+1

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- wen  in  1  write request
- wdata  in  WIDTH  write data, sampled with wen
- ren  in  1  read request
- rdata  out  WIDTH  registered read data
- rvalid  out  1  rdata holds data from a read accepted on the previous edge
- count  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- overflow  out  1  one-cycle pulse: write hit a full FIFO
- underflow  out  1  one-cycle pulse: read hit an empty FIFO
- err_cnt  out  8  saturating error count (only with PFIFO_ERR_CNT_EN)

## Operation
- Storage: DEPTH×WIDTH array; write pointer wptr and read pointer rptr, AW bits each, wrap DEPTH-1 → 0 naturally; occupancy kept as a separate count register.
- Accept rules, evaluated on current (pre-edge) count:
  - Read accepted iff ren && count > 0. No bypass: a read on an empty FIFO is rejected even with a concurrent write.
  - Write accepted iff wen && (count < DEPTH || read accepted this cycle || OVERWRITE).
- Write accepted: mem[wptr] ← wdata, wptr += 1.
- Read accepted: rdata ← mem[rptr], rptr += 1, rvalid ← 1; otherwise rvalid ← 0 and rdata holds its value.
- count: +1 on write only, −1 on read only, unchanged when both or neither happen. Exception: overwrite-at-full.
- Full, wen, no accepted read:
  - OVERWRITE=0: write dropped; pointers and count unchanged; overflow ← 1.
  - OVERWRITE=1: write stored at wptr (== rptr), wptr += 1, rptr += 1, count stays DEPTH; overflow ← 1.
- Full, wen && ren: both accepted, count stays DEPTH, no overflow.
- Empty, ren: no pointer movement (no skip), rvalid ← 0, underflow ← 1. A concurrent wen is accepted (count → 1).
- Invariant: count == (wptr − rptr) mod DEPTH, except count == DEPTH when wptr == rptr and the FIFO is full.
- No internal state machine beyond pointers, count and the output registers.

## Timing
- Synchronous reset: wptr, rptr, count ← 0; rdata ← 0; rvalid, overflow, underflow ← 0; full ← 0; empty ← 1; almost_full ← 0; almost_empty ← 1. err_cnt ← 0. Memory contents are not reset.
- Reset asserted mid-operation discards all contents at that edge. wen/ren in the reset cycle are ignored.
- Read latency 1: data for a read accepted at edge N is on rdata with rvalid=1 after edge N; back-to-back reads give one word per cycle.
- Status flags (full, empty, almost_*) decode the count register and change in the cycle after the causing edge, never combinationally from wen/ren.
- overflow and underflow are registered, high for exactly one cycle after the offending edge.
- Write-to-read: a word written at edge N is readable by a ren sampled at edge N+1 at the earliest.

## Configuration
- PFIFO_ERR_CNT_EN defined: err_cnt port present; it increments by 1 on each overflow or underflow event (both in one cycle is not possible). It saturates at 255 and clears only on rst.
- Not defined: err_cnt port and its logic are absent; all other behaviour is identical.

## Test plan
Tests use WIDTH=8 and DEPTH=8 unless noted.
- Fill/drain: 8 writes 0x10..0x17, then 8 reads → full=1 after the 8th write; rdata 0x10..0x17 in order, each with rvalid=1; then empty=1, count=0.
- Drop at full, OVERWRITE=0: fill with 0x10..0x17, write 0xAA → overflow pulses once, count=8; drain returns 0x10..0x17, with no 0xAA.
- Overwrite at full, OVERWRITE=1: fill with 0x10..0x17, write 0xAA → overflow pulses once, count=8; drain returns 0x11..0x17, 0xAA.
- Empty read: ren on an empty FIFO → underflow pulses once, rvalid=0, pointers unchanged. Simultaneous wen 0x55 + ren on empty → count=1, underflow=1, and the next read returns 0x55. With PFIFO_ERR_CNT_EN, err_cnt=2 after both cases.
- Flags/wrap, AF_THRESH=6, AE_THRESH=1: run 20 write+read cycles with count held at 3, then fill → almost_full rises when count reaches 6 and almost_empty falls when count reaches 2; data integrity holds across the pointer wrap.
- Reset mid-stream: assert rst with count=5 and ren=1 → next cycle count=0, empty=1, rvalid=0, overflow=0; the next write/read pair returns the newly written word.

Source files
------------

// File: rtl/param_fifo_if.sv
// Port bundle for param_fifo: producer/consumer requests plus FIFO status.
// err_cnt exists only when PFIFO_ERR_CNT_EN is defined.
interface param_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: wen/ren are requests with no ready; the FIFO decides acceptance
  // from its pre-edge count. rdata is qualified by rvalid for exactly one cycle,
  // and rejected requests are reported by the overflow/underflow pulses.
  logic             wen;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
`ifdef PFIFO_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  modport master (
    output wen, wdata, ren,
    input  rdata, rvalid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
`ifdef PFIFO_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  wen, wdata, ren,
    output rdata, rvalid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
`ifdef PFIFO_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with registered read port and drop/overwrite policy at full.
// Optional saturating error counter enabled by defining PFIFO_ERR_CNT_EN.
module param_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic         clk,
  input  logic         rst,
  param_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q, ovf_q, unf_q;

  logic is_full, is_empty, rd_acc, wr_acc, wr_evict, ovf_ev, unf_ev;

  always_comb begin
    is_full  = (cnt == FULL_CNT);
    is_empty = (cnt == '0);
    rd_acc   = bus.ren && !is_empty;
    wr_acc   = bus.wen && (!is_full || rd_acc || (OVERWRITE != 0));
    // A write into a full FIFO without a read must push the oldest entry out.
    wr_evict = wr_acc && is_full && !rd_acc;
    ovf_ev   = bus.wen && is_full && !rd_acc;
    unf_ev   = bus.ren && is_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wptr] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      ovf_q    <= ovf_ev;
      unf_q    <= unf_ev;
      if (rd_acc) rdata_q <= mem[rptr];
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc || wr_evict) rptr <= rptr + 1'b1;
      if (wr_acc && !rd_acc && !is_full) cnt <= cnt + 1'b1;
      else if (rd_acc && !wr_acc)        cnt <= cnt - 1'b1;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.count        = cnt;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (cnt >= AF_CNT);
  assign bus.almost_empty = (cnt <= AE_CNT);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

`ifdef PFIFO_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else if ((ovf_ev || unf_ev) && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign bus.err_cnt = err_q;
`endif
endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: two instances (drop and overwrite policy) share one stimulus
// stream; each has a queue model compared every cycle, plus literal directed checks.
module tb_param_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             wen = 1'b0;
  logic             ren = 1'b0;
  logic [WIDTH-1:0] wdata = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // lane 0: drop at full, lane 1: overwrite oldest
  for (genvar g = 0; g < 2; g++) begin : lane
    param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(g), .AF_THRESH(6), .AE_THRESH(1)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );

    assign bus.wen   = wen;
    assign bus.wdata = wdata;
    assign bus.ren   = ren;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] m_rdata = '0;
    logic             m_rvalid = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    int               m_err = 0;
    bit               armed = 1'b0;

    // behavioural model: a plain queue of stored words
    always @(posedge clk) begin
      if (rst) begin
        exp_q.delete();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_err    = 0;
        armed    = 1'b1;
      end else begin
        m_rvalid = ren && (exp_q.size() > 0);
        m_unf    = ren && (exp_q.size() == 0);
        m_ovf    = 1'b0;
        if (m_rvalid) begin
          m_rdata = exp_q.pop_front();
          got_q.push_back(m_rdata);
        end
        if (wen) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(wdata);
          else begin
            m_ovf = 1'b1;
            if (g == 1) begin
              exp_q.delete(0);
              exp_q.push_back(wdata);
            end
          end
        end
        if ((m_ovf || m_unf) && m_err < 255) m_err++;
      end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("l%0d count", g), int'(bus.count), exp_q.size());
        chk($sformatf("l%0d full", g), int'(bus.full), int'(exp_q.size() == DEPTH));
        chk($sformatf("l%0d empty", g), int'(bus.empty), int'(exp_q.size() == 0));
        chk($sformatf("l%0d almost_full", g), int'(bus.almost_full), int'(exp_q.size() >= 6));
        chk($sformatf("l%0d almost_empty", g), int'(bus.almost_empty), int'(exp_q.size() <= 1));
        chk($sformatf("l%0d rvalid", g), int'(bus.rvalid), int'(m_rvalid));
        chk($sformatf("l%0d rdata", g), int'(bus.rdata), int'(m_rdata));
        chk($sformatf("l%0d overflow", g), int'(bus.overflow), int'(m_ovf));
        chk($sformatf("l%0d underflow", g), int'(bus.underflow), int'(m_unf));
`ifdef PFIFO_ERR_CNT_EN
        chk($sformatf("l%0d err_cnt", g), int'(bus.err_cnt), m_err);
`endif
      end
    end
  end

  // driver tasks: inputs change on the falling edge, return #1 after the rising edge
  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
    @(negedge clk);
    rst = 1'b0; wen = w; wdata = d; ren = r;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
    @(negedge clk);
    rst = 1'b1; wen = w; wdata = d; ren = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string nm, input int lane_id, input int idx, input int exp);
    int act;
    act = -1;
    if (lane_id == 0 && idx < lane[0].got_q.size()) act = int'(lane[0].got_q[idx]);
    if (lane_id == 1 && idx < lane[1].got_q.size()) act = int'(lane[1].got_q[idx]);
    chk(nm, act, exp);
  endtask

  int exp_words[$];

  initial begin
    // reset state
    reset_cyc(1'b1, 8'hEE, 1'b1);
    chk("rst count", int'(lane[0].bus.count), 0);
    chk("rst empty", int'(lane[0].bus.empty), 1);
    chk("rst almost_empty", int'(lane[1].bus.almost_empty), 1);
    chk("rst rvalid", int'(lane[1].bus.rvalid), 0);

    // fill 0x10..0x17 with flag edge checks
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 0) chk("fill1 almost_empty", int'(lane[0].bus.almost_empty), 1);
      if (i == 1) chk("fill2 almost_empty", int'(lane[0].bus.almost_empty), 0);
      if (i == 4) chk("fill5 almost_full", int'(lane[0].bus.almost_full), 0);
      if (i == 5) chk("fill6 almost_full", int'(lane[0].bus.almost_full), 1);
      if (i == 6) chk("fill7 full", int'(lane[0].bus.full), 0);
    end
    chk("fill8 full l0", int'(lane[0].bus.full), 1);
    chk("fill8 full l1", int'(lane[1].bus.full), 1);

    // write at full: drop on lane 0, overwrite on lane 1
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf pulse l0", int'(lane[0].bus.overflow), 1);
    chk("ovf pulse l1", int'(lane[1].bus.overflow), 1);
    chk("ovf count l1", int'(lane[1].bus.count), 8);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf one-shot l0", int'(lane[0].bus.overflow), 0);

    lane[0].got_q.delete();
    lane[1].got_q.delete();
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) chk_got($sformatf("drop drain[%0d]", i), 0, i, 8'h10 + i);
    for (int i = 0; i < 7; i++) chk_got($sformatf("ovw drain[%0d]", i), 1, i, 8'h11 + i);
    chk_got("ovw drain[7]", 1, 7, 8'hAA);
    chk("drained empty", int'(lane[0].bus.empty), 1);
    chk("drained count", int'(lane[1].bus.count), 0);

    // empty read, then simultaneous write+read on empty
    cyc(1'b0, 8'h00, 1'b1);
    chk("empty rd underflow", int'(lane[0].bus.underflow), 1);
    chk("empty rd rvalid", int'(lane[0].bus.rvalid), 0);
    cyc(1'b1, 8'h55, 1'b1);
    chk("wr+rd empty count", int'(lane[0].bus.count), 1);
    chk("wr+rd empty underflow", int'(lane[0].bus.underflow), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("read back 0x55", int'(lane[0].bus.rdata), 8'h55);
    chk("read back rvalid", int'(lane[0].bus.rvalid), 1);
`ifdef PFIFO_ERR_CNT_EN
    // one overflow and two underflows so far on each lane
    chk("err_cnt l0", int'(lane[0].bus.err_cnt), 3);
    chk("err_cnt l1", int'(lane[1].bus.err_cnt), 3);
`endif

    // steady-state streaming at count 3 across pointer wrap, then refill
    lane[0].got_q.delete();
    lane[1].got_q.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h23 + i), 1'b1);
      chk($sformatf("stream count[%0d]", i), int'(lane[0].bus.count), 3);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(8'h40 + i), 1'b0);
      if (i == 1) chk("refill5 almost_full", int'(lane[1].bus.almost_full), 0);
      if (i == 2) chk("refill6 almost_full", int'(lane[1].bus.almost_full), 1);
    end
    cyc(1'b1, 8'h45, 1'b1);
    chk("full wr+rd count", int'(lane[1].bus.count), 8);
    chk("full wr+rd no ovf", int'(lane[1].bus.overflow), 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    exp_words.delete();
    for (int i = 0; i < 23; i++) exp_words.push_back(8'h20 + i);
    for (int i = 0; i < 6; i++) exp_words.push_back(8'h40 + i);
    chk("wrap total reads", lane[0].got_q.size(), 29);
    foreach (exp_words[i]) begin
      chk_got($sformatf("wrap l0[%0d]", i), 0, i, exp_words[i]);
      chk_got($sformatf("wrap l1[%0d]", i), 1, i, exp_words[i]);
    end

    // reset with count 5 and a pending read
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    chk("pre-rst count", int'(lane[0].bus.count), 5);
    reset_cyc(1'b0, 8'h00, 1'b1);
    chk("mid-rst count", int'(lane[0].bus.count), 0);
    chk("mid-rst empty", int'(lane[0].bus.empty), 1);
    chk("mid-rst rvalid", int'(lane[0].bus.rvalid), 0);
    chk("mid-rst overflow", int'(lane[1].bus.overflow), 0);
`ifdef PFIFO_ERR_CNT_EN
    chk("mid-rst err_cnt", int'(lane[0].bus.err_cnt), 0);
`endif
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post-rst rdata", int'(lane[0].bus.rdata), 8'h77);
    chk("post-rst rvalid", int'(lane[1].bus.rvalid), 1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
